// File: rtl/erx_protocol.sv
// erx_protocol: receive-side protocol stage of the elink.
//   Takes beats from the RX IO deserializer, rebuilds a full emesh packet for
//   every beat (burst beats carry only data/srcaddr), and buffers the packets
//   in a DEPTH-entry FIFO toward emesh. Generates rx_wr_wait/rx_rd_wait
//   pushback from the FIFO occupancy.
//
//   Build option: define ERX_BURST_EN to enable burst reconstruction. When it
//   is undefined, rx_burst is ignored, every valid beat passes verbatim and
//   burst_err is tied to 0.
//
// Ports:
//   clk, nreset        clock, synchronous active-low reset
//   rx_access/burst    beat valid / beat continues previous beat
//   rx_packet          beat contents (PW bits)
//   rx_wr_wait/rd_wait pushback to the IO
//   erx_access/packet  FIFO head toward emesh
//   erx_wait           emesh stall
//   burst_err/ovf_err  sticky error flags
//
// State table (stage-1 FSM, ERX_BURST_EN only):
//   state    | meaning
//   ST_IDLE  | expecting a header; a burst beat here is an orphan
//   ST_BURST | last header was a double write; burst beats are rebuilt
module erx_protocol #(
  parameter int PW    = 104,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          rx_access,
  input  logic          rx_burst,
  input  logic [PW-1:0] rx_packet,
  output logic          rx_wr_wait,
  output logic          rx_rd_wait,
  output logic          erx_access,
  output logic [PW-1:0] erx_packet,
  input  logic          erx_wait,
  output logic          burst_err,
  output logic          ovf_err
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CW   = PTRW + 1;

  // stage-1 output register
  logic          s1_valid_q;
  logic [PW-1:0] s1_packet_q;

`ifdef ERX_BURST_EN
  localparam int DST_LSB  = 8;
  localparam int DATA_LSB = DST_LSB + AW;
  localparam int SRC_LSB  = DATA_LSB + DW;

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t        state_q;
  logic          hdr_write_q;
  logic [1:0]    hdr_datamode_q;
  logic [3:0]    hdr_ctrlmode_q;
  logic [AW-1:0] hdr_dstaddr_q;
  logic [AW-1:0] burst_dst_d;
  logic          burst_err_q;

  // natural wrap at 2^AW
  assign burst_dst_d = hdr_dstaddr_q + AW'(8);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q        <= ST_IDLE;
      s1_valid_q     <= 1'b0;
      s1_packet_q    <= '0;
      hdr_write_q    <= 1'b0;
      hdr_datamode_q <= 2'b00;
      hdr_ctrlmode_q <= 4'h0;
      hdr_dstaddr_q  <= '0;
      burst_err_q    <= 1'b0;
    end else begin
      s1_valid_q <= 1'b0;
      if (rx_access) begin
        if (!rx_burst) begin
          s1_valid_q     <= 1'b1;
          s1_packet_q    <= rx_packet;
          hdr_write_q    <= rx_packet[1];
          hdr_datamode_q <= rx_packet[3:2];
          hdr_ctrlmode_q <= rx_packet[7:4];
          hdr_dstaddr_q  <= rx_packet[DST_LSB +: AW];
          state_q        <= (rx_packet[1] && rx_packet[3:2] == 2'b11) ? ST_BURST : ST_IDLE;
        end else if (state_q == ST_BURST) begin
          s1_valid_q    <= 1'b1;
          s1_packet_q   <= {rx_packet[PW-1:SRC_LSB], rx_packet[DATA_LSB +: DW], burst_dst_d,
                            hdr_ctrlmode_q, hdr_datamode_q, hdr_write_q, 1'b1};
          hdr_dstaddr_q <= burst_dst_d;
        end else begin
          // burst beat with no header in front of it
          burst_err_q <= 1'b1;
        end
      end
    end
  end

  assign burst_err = burst_err_q;
`else
  localparam int unused_widths = AW + DW;
  logic unused_burst;
  assign unused_burst = rx_burst;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      s1_valid_q  <= 1'b0;
      s1_packet_q <= '0;
    end else begin
      s1_valid_q <= rx_access;
      if (rx_access) s1_packet_q <= rx_packet;
    end
  end

  assign burst_err = 1'b0;
`endif

  // stage-2 FIFO; the head is presented through registers so a freshly
  // written entry becomes visible one cycle after its write
  logic [PW-1:0]   mem_q [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            pop, full, wr_ok, avail;
  logic            erx_access_q;
  logic [PW-1:0]   erx_packet_q;
  logic            ovf_err_q, rx_wr_wait_q, rx_rd_wait_q;

  assign pop   = erx_access_q & ~erx_wait;
  assign full  = (count_q == CW'(DEPTH));
  assign wr_ok = s1_valid_q & (~full | pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q + PTRW'(pop);
    count_d  = count_q + CW'(wr_ok) - CW'(pop);
    // entries already stored before this edge, minus the one leaving now
    avail    = ((count_q - CW'(pop)) != '0);
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= s1_packet_q;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      erx_access_q <= 1'b0;
      erx_packet_q <= '0;
      ovf_err_q    <= 1'b0;
      rx_wr_wait_q <= 1'b0;
      rx_rd_wait_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_q + PTRW'(wr_ok);
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      erx_access_q <= avail;
      erx_packet_q <= avail ? mem_q[rd_ptr_d] : '0;
      if (s1_valid_q && full && !pop) ovf_err_q <= 1'b1;
      // reads throttled one slot earlier than writes
      rx_wr_wait_q <= (count_q >= CW'(DEPTH - 2));
      rx_rd_wait_q <= (count_q >= CW'(DEPTH - 3));
    end
  end

  assign erx_access = erx_access_q;
  assign erx_packet = erx_packet_q;
  assign ovf_err    = ovf_err_q;
  assign rx_wr_wait = rx_wr_wait_q;
  assign rx_rd_wait = rx_rd_wait_q;

endmodule
